// File: rtl/nes_fetch_pkg.sv
// Shared types and constants for the 6502 instruction prefetch path.
package nes_fetch_pkg;

  typedef logic [1:0] state_t;
  localparam state_t VEC_LO   = 2'd0;
  localparam state_t VEC_HI   = 2'd1;
  localparam state_t VEC_DONE = 2'd2;
  localparam state_t RUN      = 2'd3;

  localparam logic [15:0] RESET_VEC = 16'hFFFC;
  localparam logic [15:0] NMI_VEC   = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC   = 16'hFFFE;

  typedef struct packed {
    logic [15:0] pc;
    logic [7:0]  data;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of PC-tagged fetch bytes; flush beats push.
module fetch_fifo
  import nes_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem_reg [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_reg[wr_ptr_reg] <= push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= next_ptr(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= next_ptr(rd_ptr_reg);
      end
      count_reg <= count_reg + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_prefetch.sv
// Byte-wide prefetch: boots from the reset vector, streams PC-tagged bytes to the decoder.
module fetch_prefetch
  import nes_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] VEC_ADDR = RESET_VEC
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] mem_raddr,
  input  logic [7:0]  mem_rdata,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        out_valid,
  output logic [7:0]  out_byte,
  output logic [15:0] out_pc,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_reg;
  logic [15:0]   fetch_pc_reg;
  logic [7:0]    vec_lo_reg;
  logic          inflight_valid_reg;
  logic [15:0]   inflight_pc_reg;

  fetch_entry_t  fifo_head;
  logic [CW-1:0] fifo_count;
  logic          in_run;
  logic          issue;
  logic          push;
  logic          pop;
  logic          flush;

  assign in_run = (state_reg == RUN);
  assign flush  = in_run && redirect;
  // A returning byte that collides with a redirect belongs to the old stream.
  assign push   = inflight_valid_reg && !flush;
  assign pop    = out_valid && out_ready;
  // Counting the in-flight byte guarantees a free slot when it lands.
  assign issue  = in_run && !redirect &&
                  ((int'(fifo_count) + int'(inflight_valid_reg)) < DEPTH);

  always_comb begin
    mem_raddr = fetch_pc_reg;
    case (state_reg)
      VEC_LO:  mem_raddr = VEC_ADDR;
      VEC_HI:  mem_raddr = VEC_ADDR + 16'd1;
      default: mem_raddr = fetch_pc_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg          <= VEC_LO;
      fetch_pc_reg       <= 16'h0000;
      vec_lo_reg         <= 8'h00;
      inflight_valid_reg <= 1'b0;
      inflight_pc_reg    <= 16'h0000;
    end else begin
      case (state_reg)
        VEC_LO: state_reg <= VEC_HI;
        VEC_HI: begin
          vec_lo_reg <= mem_rdata;
          state_reg  <= VEC_DONE;
        end
        VEC_DONE: begin
          fetch_pc_reg <= {mem_rdata, vec_lo_reg};
          state_reg    <= RUN;
        end
        RUN: begin
          if (redirect) begin
            fetch_pc_reg       <= redirect_pc;
            inflight_valid_reg <= 1'b0;
          end else begin
            inflight_valid_reg <= issue;
            if (issue) begin
              inflight_pc_reg <= fetch_pc_reg;
              fetch_pc_reg    <= fetch_pc_reg + 16'd1;
            end
          end
        end
        default: state_reg <= VEC_LO;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry ('{pc: inflight_pc_reg, data: mem_rdata}),
    .pop        (pop),
    .flush      (flush),
    .head       (fifo_head),
    .count      (fifo_count)
  );

  // Head is gated so stale storage never shows on an empty FIFO.
  assign out_valid = (fifo_count != '0);
  assign out_byte  = out_valid ? fifo_head.data : 8'h00;
  assign out_pc    = out_valid ? fifo_head.pc : 16'h0000;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench with a stream-level reference model for fetch_prefetch.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] mem_raddr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic [15:0] out_pc;
  logic        out_ready = 1'b0;

  logic [7:0]  mem [0:65535];
  int n_cmp = 0;
  int n_bad = 0;

  fetch_prefetch #(.DEPTH(4), .VEC_ADDR(16'hFFFC)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_raddr   (mem_raddr),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .out_valid   (out_valid),
    .out_byte    (out_byte),
    .out_pc      (out_pc),
    .out_ready   (out_ready)
  );

  always #5 clk = ~clk;

  // One-cycle read latency memory.
  always @(posedge clk) mem_rdata <= mem[mem_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delivered bytes form a consecutive PC stream starting at
  // the vector (after reset) or at the redirect target; data is mem[pc].
  logic [15:0] exp_pc = 16'h0000;
  int cyc = 0;
  int since_redir = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        check("stream_pc", {16'h0, out_pc}, {16'h0, exp_pc});
        check("stream_byte", {24'h0, out_byte}, {24'h0, mem[exp_pc]});
      end
      if (cyc < 5) check("boot_gap_valid", {31'h0, out_valid}, 32'd0);
      if (since_redir > 0 && since_redir < 3)
        check("redir_gap_valid", {31'h0, out_valid}, 32'd0);
    end
    // Predict the effect of the coming edge (inputs are stable until then).
    if (reset) begin
      cyc = 0;
      since_redir = 0;
      exp_pc = {mem[16'hFFFD], mem[16'hFFFC]};
    end else begin
      if (redirect && cyc >= 3) begin
        exp_pc = redirect_pc;
        since_redir = 1;
      end else begin
        if (out_valid && out_ready) exp_pc = exp_pc + 16'd1;
        if (since_redir != 0) since_redir = (since_redir >= 3) ? 0 : since_redir + 1;
      end
      if (cyc < 1000) cyc++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    check("rst_valid", {31'h0, out_valid}, 32'd0);
    check("rst_byte", {24'h0, out_byte}, 32'd0);
    check("rst_pc", {16'h0, out_pc}, 32'd0);
    check("rst_raddr", {16'h0, mem_raddr}, 32'h0000FFFC);
    step();
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_edges);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check(name, n, exp_edges);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'(i) ^ 8'(i >> 8);

    // Boot from the reset vector and stream.
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    mem[16'hC000] = 8'hA9; mem[16'hC001] = 8'h01;
    mem[16'hC002] = 8'h8D; mem[16'hC003] = 8'h00;
    out_ready = 1'b1;
    do_reset();
    check("boot_raddr_lo", {16'h0, mem_raddr}, 32'h0000FFFC);
    step();
    check("boot_raddr_hi", {16'h0, mem_raddr}, 32'h0000FFFD);
    wait_valid("boot_latency", 4);
    for (int i = 0; i < 4; i++) begin
      logic [7:0] exp_b [4];
      exp_b = '{8'hA9, 8'h01, 8'h8D, 8'h00};
      check("boot_seq_valid", {31'h0, out_valid}, 32'd1);
      check("boot_seq_pc", {16'h0, out_pc}, 32'hC000 + 32'(i));
      check("boot_seq_byte", {24'h0, out_byte}, {24'h0, exp_b[i]});
      step();
    end

    // Backpressure: fill, stall at C004, then drain without loss.
    out_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) step();
    check("bp_head_pc", {16'h0, out_pc}, 32'h0000C000);
    check("bp_stall_raddr", {16'h0, mem_raddr}, 32'h0000C004);
    step(); step();
    check("bp_stall_hold", {16'h0, mem_raddr}, 32'h0000C004);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bp_drain_valid", {31'h0, out_valid}, 32'd1);
      check("bp_drain_pc", {16'h0, out_pc}, 32'hC000 + 32'(i));
      step();
    end

    // Redirect while the C002 read is pending.
    do_reset();
    wait_valid("rd_boot_latency", 5);
    check("rd_first_pc", {16'h0, out_pc}, 32'h0000C000);
    step();
    check("rd_head_pc", {16'h0, out_pc}, 32'h0000C001);
    check("rd_pending_raddr", {16'h0, mem_raddr}, 32'h0000C003);
    redirect = 1'b1; redirect_pc = 16'hC100;
    step();
    redirect = 1'b0;
    check("rd_gap1_valid", {31'h0, out_valid}, 32'd0);
    check("rd_target_raddr", {16'h0, mem_raddr}, 32'h0000C100);
    step();
    check("rd_gap2_valid", {31'h0, out_valid}, 32'd0);
    step();
    check("rd_resume_valid", {31'h0, out_valid}, 32'd1);
    check("rd_resume_pc", {16'h0, out_pc}, 32'h0000C100);
    check("rd_resume_byte", {24'h0, out_byte}, 32'h000000C1);

    // Wrap-around of the fetch PC.
    mem[16'hFFFC] = 8'hFE; mem[16'hFFFD] = 8'hFF;
    mem[16'hFFFE] = 8'h11; mem[16'hFFFF] = 8'h22; mem[16'h0000] = 8'h33;
    do_reset();
    wait_valid("wrap_latency", 5);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] wp [3];
      logic [7:0]  wb [3];
      wp = '{16'hFFFE, 16'hFFFF, 16'h0000};
      wb = '{8'h11, 8'h22, 8'h33};
      check("wrap_pc", {16'h0, out_pc}, {16'h0, wp[i]});
      check("wrap_byte", {24'h0, out_byte}, {24'h0, wb[i]});
      step();
    end

    // Redirect during the vector fetch is ignored.
    mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'hC0;
    do_reset();
    step();
    redirect = 1'b1; redirect_pc = 16'h8000;
    step();
    redirect = 1'b0;
    wait_valid("vecrd_latency", 3);
    check("vecrd_pc", {16'h0, out_pc}, 32'h0000C000);

    // Reset mid-run with a full FIFO.
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("mid_full_valid", {31'h0, out_valid}, 32'd1);
    do_reset();
    check("mid_raddr_lo", {16'h0, mem_raddr}, 32'h0000FFFC);
    step();
    check("mid_raddr_hi", {16'h0, mem_raddr}, 32'h0000FFFD);
    wait_valid("mid_latency", 4);
    check("mid_pc", {16'h0, out_pc}, 32'h0000C000);
    check("mid_byte", {24'h0, out_byte}, 32'h000000A9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
